// File: rtl/pipelined_cla_addsub.sv
// Pipelined add/subtract built from 4-bit carry-lookahead groups, one group per stage.
// Latency: WIDTH/4 cycles from the accept edge to out_valid; one operand set per cycle.
// Backpressure: out_valid && !out_ready freezes every stage and drops in_ready.
module pipelined_cla_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             ovf,
  output logic             zero
);

  // WIDTH must be a multiple of 4 and at least 4.
  localparam int NG = WIDTH / 4;

  // 4-bit lookahead unit: every carry is a flat sum of products of the
  // group carry-in, so nothing ripples inside the group. Returns {c4, s[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  logic stall;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall & ~rst;

  // Input register stage: subtraction is folded in here as A + ~B + 1, so the
  // group stages only ever add.
  logic             v0_q;
  logic [WIDTH-1:0] a0_q;
  logic [WIDTH-1:0] b0_q;
  logic             c0_q;

  // Capture an operand set whenever the pipe moves; in_valid=0 enters as a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q <= 1'b0;
    end else if (!stall) begin
      v0_q <= in_valid;
      a0_q <= A_in;
      b0_q <= sub ? ~B_in : B_in;
      c0_q <= sub | Cin;
    end
  end

  // Stage g+1 resolves group g. Operand registers shrink by one group per
  // stage (only unconsumed bits travel on), completed sum bits grow by one group.
  for (genvar g = 0; g < NG; g++) begin : st
    localparam int RW = WIDTH - 4 * g;

    logic            v_src;
    logic            c_src;
    logic [RW-1:0]   a_src;
    logic [RW-1:0]   b_src;
    logic [4:0]      grp_d;
    logic [4*g+3:0]  s_d;
    logic            v_q;
    logic            c_q;
    logic [4*g+3:0]  s_q;

    if (g == 0) begin : src
      assign v_src = v0_q;
      assign c_src = c0_q;
      assign a_src = a0_q;
      assign b_src = b0_q;
      assign s_d   = grp_d[3:0];
    end else begin : src
      assign v_src = st[g-1].v_q;
      assign c_src = st[g-1].c_q;
      assign a_src = st[g-1].op.a_q;
      assign b_src = st[g-1].op.b_q;
      assign s_d   = {grp_d[3:0], st[g-1].s_q};
    end

    assign grp_d = cla4(a_src[3:0], b_src[3:0], c_src);

    // Advance valid, group carry-out and completed sum bits; hold while stalled.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (!stall) begin
        v_q <= v_src;
        c_q <= grp_d[4];
        s_q <= s_d;
      end
    end

    if (g < NG - 1) begin : op
      logic [RW-5:0] a_q;
      logic [RW-5:0] b_q;

      // Forward the operand bits later groups still need.
      always_ff @(posedge clk) begin
        if (!stall) begin
          a_q <= a_src[RW-1:4];
          b_q <= b_src[RW-1:4];
        end
      end
    end else begin : fl
      logic ovf_q;
      logic zero_q;

      // Flags are formed from the final group so they land with the sum.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (!stall) begin
          ovf_q  <= (a_src[3] == b_src[3]) && (grp_d[3] != a_src[3]);
          zero_q <= (s_d == '0);
        end
      end
    end
  end

  assign out_valid = st[NG-1].v_q;
  assign sum       = st[NG-1].s_q;
  assign Cout      = st[NG-1].c_q;
  assign ovf       = st[NG-1].fl.ovf_q;
  assign zero      = st[NG-1].fl.zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed bench for pipelined_cla_addsub at WIDTH=16.
module tb_pipelined_cla_addsub;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic             Cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             Cout;
  logic             ovf;
  logic             zero;

  int n_checks = 0;
  int n_fail   = 0;

  pipelined_cla_addsub #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A_in(A_in), .B_in(B_in), .Cin(Cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .Cout(Cout), .ovf(ovf), .zero(zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set and let it be accepted on the next edge.
  task automatic send_one(input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic s);
    A_in = a; B_in = b; Cin = ci; sub = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid shows; -1 on timeout.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    A_in = 16'h1234; B_in = 16'h4321; Cin = 1'b1; sub = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready0: got %b want 0", in_ready); end
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready1: got %b want 0", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum: got %h want 0000", sum); end
    n_checks++; if ({Cout, ovf, zero} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {Cout, ovf, zero}); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready2: got %b want 0", in_ready); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_add_carry_zero();
    int lat;
    send_one(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_out(lat);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL add_latency: got %0d want 4", lat); end
    n_checks++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL add_sum: got %h want 0000", sum); end
    n_checks++; if ({Cout, ovf, zero} !== 3'b101) begin n_fail++; $display("FAIL add_flags(C,V,Z): got %b want 101", {Cout, ovf, zero}); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_single_result: got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_signed_ovf();
    logic [15:0] ta [2] = '{16'h7FFF, 16'h8000};
    logic [15:0] tb [2] = '{16'h0001, 16'h8000};
    logic [15:0] ts [2] = '{16'h8000, 16'h0000};
    logic [2:0]  tf [2] = '{3'b010, 3'b111};
    int lat;
    for (int i = 0; i < 2; i++) begin
      send_one(ta[i], tb[i], 1'b0, 1'b0);
      wait_out(lat);
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL ovf_latency[%0d]: got %0d want 4", i, lat); end
      n_checks++; if (sum !== ts[i]) begin n_fail++; $display("FAIL ovf_sum[%0d]: got %h want %h", i, sum, ts[i]); end
      n_checks++; if ({Cout, ovf, zero} !== tf[i]) begin n_fail++; $display("FAIL ovf_flags[%0d](C,V,Z): got %b want %b", i, {Cout, ovf, zero}, tf[i]); end
    end
  endtask

  task automatic test_subtract();
    logic [15:0] ta [3] = '{16'h0005, 16'h1234, 16'h8000};
    logic [15:0] tb [3] = '{16'h0007, 16'h1234, 16'h0001};
    logic        tc [3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] ts [3] = '{16'hFFFE, 16'h0000, 16'h7FFF};
    logic [2:0]  tf [3] = '{3'b000, 3'b101, 3'b110};
    int lat;
    for (int i = 0; i < 3; i++) begin
      send_one(ta[i], tb[i], tc[i], 1'b1);
      wait_out(lat);
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL sub_latency[%0d]: got %0d want 4", i, lat); end
      n_checks++; if (sum !== ts[i]) begin n_fail++; $display("FAIL sub_sum[%0d]: got %h want %h", i, sum, ts[i]); end
      n_checks++; if ({Cout, ovf, zero} !== tf[i]) begin n_fail++; $display("FAIL sub_flags[%0d](C,V,Z): got %b want %b", i, {Cout, ovf, zero}, tf[i]); end
    end
  endtask

  task automatic test_carry_chain();
    logic [15:0] ta [3] = '{16'h00FF, 16'h0FFF, 16'hFFFF};
    logic [15:0] tb [3] = '{16'h0F00, 16'h0000, 16'h0000};
    logic [15:0] ts [3] = '{16'h1000, 16'h1000, 16'h0000};
    logic [2:0]  tf [3] = '{3'b000, 3'b000, 3'b101};
    int lat;
    for (int i = 0; i < 3; i++) begin
      send_one(ta[i], tb[i], 1'b1, 1'b0);
      wait_out(lat);
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL chain_latency[%0d]: got %0d want 4", i, lat); end
      n_checks++; if (sum !== ts[i]) begin n_fail++; $display("FAIL chain_sum[%0d]: got %h want %h", i, sum, ts[i]); end
      n_checks++; if ({Cout, ovf, zero} !== tf[i]) begin n_fail++; $display("FAIL chain_flags[%0d](C,V,Z): got %b want %b", i, {Cout, ovf, zero}, tf[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    int   idx;
    out_ready = 1'b1;
    for (int c = 0; c < 22; c++) begin
      if (c < 16) begin
        A_in = 16'(c); B_in = 16'(c); Cin = ((c % 2) != 0); sub = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      exp_v = (c >= 4) && (c < 20);
      n_checks++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL b2b_valid[c=%0d]: got %b want %b", c, out_valid, exp_v); end
      if (exp_v) begin
        idx = c - 4;
        n_checks++; if (sum !== 16'(2 * idx + idx % 2)) begin n_fail++; $display("FAIL b2b_sum[%0d]: got %h want %h", idx, sum, 16'(2 * idx + idx % 2)); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] q[$];
    logic [15:0] snap;
    logic        accept;
    logic        take;
    int          sent = 0;
    int          got  = 0;
    for (int c = 0; c < 60 && got < 12; c++) begin
      out_ready = !(c >= 6 && c < 12);
      if (sent < 12) begin
        A_in = 16'(sent * 16'h0111); B_in = 16'h1000; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      accept = in_valid && in_ready;
      take   = out_valid && out_ready;
      if (c >= 6 && c < 12) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[c=%0d]: got %b want 0", c, in_ready); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[c=%0d]: got %b want 1", c, out_valid); end
        if (c == 6) snap = sum;
        else begin
          n_checks++; if (sum !== snap) begin n_fail++; $display("FAIL bp_frozen[c=%0d]: got %h want %h", c, sum, snap); end
        end
      end
      if (take) begin
        n_checks++;
        if (q.size() == 0) begin n_fail++; $display("FAIL bp_extra_result: got %h want none", sum); end
        else begin
          if (sum !== q[0]) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", got, sum, q[0]); end
          void'(q.pop_front());
        end
        got++;
      end
      if (accept) begin
        q.push_back(A_in + B_in);
        sent++;
      end
      tick();
    end
    n_checks++; if (got !== 12) begin n_fail++; $display("FAIL bp_count: got %0d want 12", got); end
    n_checks++; if (q.size() !== 0) begin n_fail++; $display("FAIL bp_lost: got %0d pending want 0", q.size()); end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_midstream();
    logic exp_v;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      A_in = 16'(16'h1111 * (i + 1)); B_in = 16'h1111; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0; rst = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready_rst: got %b want 0", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid_rst: got %b want 0", out_valid); end
    n_checks++; if ({sum, Cout, ovf, zero} !== 19'h0) begin n_fail++; $display("FAIL mid_outputs_rst: got %h want 0", {sum, Cout, ovf, zero}); end
    rst = 1'b0;
    A_in = 16'h0003; B_in = 16'h0004; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_first_accept_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_v = (k == 4);
      n_checks++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL mid_valid[k=%0d]: got %b want %b", k, out_valid, exp_v); end
      if (k == 4) begin
        n_checks++; if (sum !== 16'h0007) begin n_fail++; $display("FAIL mid_post_reset_sum: got %h want 0007", sum); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add_carry_zero();
    test_signed_ovf();
    test_subtract();
    test_carry_chain();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
